// File: rtl/a2d_rr_sched.sv
// a2d_rr_sched: round-robin conversion scheduler for the ADC128S A2D path.
// Cycles through the left load cell, right load cell and battery channels.
// Each conversion is two SPI transactions: the first selects the channel and
// the second reads the result back. The latest 12-bit result of each channel
// is held in its own register.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for nxt; ptr selects the channel to convert next
// TX1   | channel-select transaction in flight; its rd_data is ignored
// GAP   | SS_n high time between transactions, counted down to zero
// TX2   | read transaction in flight; result captured on done
// UPD   | rdy pulse out, ptr advances, return to IDLE
`timescale 1ns/1ps
module a2d_rr_sched #(
    parameter logic [2:0]  LFT_CH  = 3'd0,
    parameter logic [2:0]  RGHT_CH = 3'd4,
    parameter logic [2:0]  BATT_CH = 3'd5,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        busy,
    output logic        rdy,
    output logic [1:0]  rdy_id
);

    // Counter only has to hold GAP_CYC-1; keep at least one bit.
    localparam int CNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX1  = 3'd1,
        S_GAP  = 3'd2,
        S_TX2  = 3'd3,
        S_UPD  = 3'd4
    } state_t;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] gap_cnt_q;
    logic [CNT_W-1:0] gap_cnt_d;
    logic             wrt_q;
    logic [15:0]      cmd_q;
    logic [15:0]      cmd_d;
    logic [11:0]      lft_q;
    logic [11:0]      rght_q;
    logic [11:0]      batt_q;
    logic             busy_q;
    logic             rdy_q;
    logic [1:0]       rdy_id_q;
    logic [2:0]       chnl;

    // The ADC only returns 12 bits; the top nibble of the SPI word is discarded.
    logic             unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:12];

    // Channel lookup, command word, pointer wrap and gap decrement.
    always_comb begin
        chnl = LFT_CH;
        case (ptr_q)
            2'd0:    chnl = LFT_CH;
            2'd1:    chnl = RGHT_CH;
            2'd2:    chnl = BATT_CH;
            default: chnl = LFT_CH;
        endcase
        cmd_d     = {2'b00, chnl, 11'h000};
        ptr_d     = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        gap_cnt_d = gap_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Conversion sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            gap_cnt_q <= '0;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            lft_q     <= 12'h000;
            rght_q    <= 12'h000;
            batt_q    <= 12'h000;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
            rdy_id_q  <= 2'd0;
        end else begin
            wrt_q <= 1'b0;
            rdy_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (nxt) begin
                        wrt_q   <= 1'b1;
                        cmd_q   <= cmd_d;
                        busy_q  <= 1'b1;
                        state_q <= S_TX1;
                    end
                end
                S_TX1: begin
                    if (done) begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        // cmd_q is left alone: the read uses the same word.
                        wrt_q   <= 1'b1;
                        state_q <= S_TX2;
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end
                S_TX2: begin
                    if (done) begin
                        case (ptr_q)
                            2'd0:    lft_q  <= rd_data[11:0];
                            2'd1:    rght_q <= rd_data[11:0];
                            2'd2:    batt_q <= rd_data[11:0];
                            default: ;
                        endcase
                        rdy_q    <= 1'b1;
                        rdy_id_q <= ptr_q;
                        state_q  <= S_UPD;
                    end
                end
                S_UPD: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign lft_ld  = lft_q;
    assign rght_ld = rght_q;
    assign batt    = batt_q;
    assign busy    = busy_q;
    assign rdy     = rdy_q;
    assign rdy_id  = rdy_id_q;

endmodule

// File: tb/tb_a2d_rr_sched.sv
// tb_a2d_rr_sched: drives a2d_rr_sched while acting as the SPI monarch and
// the ADC, and compares against a round-robin reference model.
`timescale 1ns/1ps
module tb_a2d_rr_sched;

    localparam int GAP_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic        busy;
    logic        rdy;
    logic [1:0]  rdy_id;

    int checks   = 0;
    int failures = 0;
    int wrt_cnt  = 0;

    // Reference model: channel table, next pointer, expected result registers.
    logic [2:0]  chan_tab [3] = '{3'd0, 3'd4, 3'd5};
    int          exp_ptr = 0;
    logic [11:0] exp_reg [3] = '{12'h000, 12'h000, 12'h000};
    // ADC model: last value per channel.
    logic [11:0] adc [8] = '{12'h000, 12'h000, 12'h000, 12'h000,
                             12'h000, 12'h000, 12'h000, 12'h000};

    a2d_rr_sched #(
        .LFT_CH (3'd0),
        .RGHT_CH(3'd4),
        .BATT_CH(3'd5),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .nxt    (nxt),
        .wrt    (wrt),
        .cmd    (cmd),
        .done   (done),
        .rd_data(rd_data),
        .lft_ld (lft_ld),
        .rght_ld(rght_ld),
        .batt   (batt),
        .busy   (busy),
        .rdy    (rdy),
        .rdy_id (rdy_id)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wrt === 1'b1) wrt_cnt++;

    function automatic logic [15:0] exp_cmd(int p);
        return {2'b00, chan_tab[p], 11'h000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion with the bench acting as SPI monarch and ADC.
    task automatic convert(input logic [3:0] upper,
                           output logic [15:0] c1, output logic [15:0] c2,
                           output int lat, output int gap,
                           output logic rdy_seen, output logic [1:0] id_seen,
                           output logic [11:0] s_l, output logic [11:0] s_r,
                           output logic [11:0] s_b,
                           output logic busy_after, output logic rdy_after);
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        lat = 1;
        while (wrt !== 1'b1 && lat < 10) begin tick(); lat++; end
        c1 = cmd;
        repeat ($urandom_range(1, 5)) tick();
        rd_data = 16'($urandom);
        done = 1'b1;
        tick();
        done = 1'b0;
        gap = 0;
        while (wrt !== 1'b1 && gap < 20) begin tick(); gap++; end
        c2 = cmd;
        repeat ($urandom_range(1, 5)) tick();
        rd_data = {upper, adc[c1[13:11]]};
        done = 1'b1;
        tick();
        done = 1'b0;
        rd_data = 16'($urandom);
        rdy_seen = rdy;
        id_seen  = rdy_id;
        s_l = lft_ld;
        s_r = rght_ld;
        s_b = batt;
        tick();
        busy_after = busy;
        rdy_after  = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; nxt = 1'b0; done = 1'b0; rd_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wrt !== 1'b0) begin failures++; $display("FAIL reset_wrt got=%b exp=0", wrt); end
        checks++; if (cmd !== 16'h0000) begin failures++; $display("FAIL reset_cmd got=%h exp=0000", cmd); end
        checks++; if (lft_ld !== 12'h000) begin failures++; $display("FAIL reset_lft got=%h exp=000", lft_ld); end
        checks++; if (rght_ld !== 12'h000) begin failures++; $display("FAIL reset_rght got=%h exp=000", rght_ld); end
        checks++; if (batt !== 12'h000) begin failures++; $display("FAIL reset_batt got=%h exp=000", batt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        checks++; if (rdy_id !== 2'd0) begin failures++; $display("FAIL reset_rdy_id got=%0d exp=0", rdy_id); end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
        exp_ptr = 0;
        for (int i = 0; i < 3; i++) exp_reg[i] = 12'h000;
    endtask

    task automatic test_round_robin();
        logic [15:0] c1, c2;
        int lat, gap, w0;
        logic rs, ba, ra;
        logic [1:0] id;
        logic [11:0] s [3];
        adc[0] = 12'h110; adc[4] = 12'h100; adc[5] = 12'hC00;
        for (int k = 0; k < 3; k++) begin
            w0 = wrt_cnt;
            convert(4'($urandom_range(0, 15)), c1, c2, lat, gap, rs, id, s[0], s[1], s[2], ba, ra);
            exp_reg[exp_ptr] = adc[chan_tab[exp_ptr]];
            checks++; if (lat != 1) begin failures++; $display("FAIL rr_nxt_lat got=%0d exp=1", lat); end
            checks++; if (c1 !== exp_cmd(exp_ptr)) begin failures++; $display("FAIL rr_cmd got=%h exp=%h", c1, exp_cmd(exp_ptr)); end
            checks++; if (c2 !== c1) begin failures++; $display("FAIL rr_cmd_stable got=%h exp=%h", c2, c1); end
            checks++; if (gap != GAP_CYC) begin failures++; $display("FAIL rr_gap got=%0d exp=%0d", gap, GAP_CYC); end
            checks++; if (rs !== 1'b1) begin failures++; $display("FAIL rr_rdy got=%b exp=1", rs); end
            checks++; if (id !== 2'(exp_ptr)) begin failures++; $display("FAIL rr_rdy_id got=%0d exp=%0d", id, exp_ptr); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (s[i] !== exp_reg[i]) begin failures++; $display("FAIL rr_reg%0d got=%h exp=%h", i, s[i], exp_reg[i]); end
            end
            checks++; if (ba !== 1'b0 || ra !== 1'b0) begin failures++; $display("FAIL rr_after got busy=%b rdy=%b exp 0 0", ba, ra); end
            checks++; if (wrt_cnt - w0 != 2) begin failures++; $display("FAIL rr_wrt_count got=%0d exp=2", wrt_cnt - w0); end
            exp_ptr = (exp_ptr + 1) % 3;
        end
    endtask

    task automatic test_update_one();
        logic [15:0] c1, c2;
        int lat, gap;
        logic rs, ba, ra;
        logic [1:0] id;
        logic [11:0] sl, sr, sb;
        adc[0] = 12'h200;
        convert(4'h0, c1, c2, lat, gap, rs, id, sl, sr, sb, ba, ra);
        checks++; if (c1 !== 16'h0000) begin failures++; $display("FAIL upd_cmd got=%h exp=0000", c1); end
        checks++; if (id !== 2'd0) begin failures++; $display("FAIL upd_rdy_id got=%0d exp=0", id); end
        checks++; if (sl !== 12'h200) begin failures++; $display("FAIL upd_lft got=%h exp=200", sl); end
        checks++; if (sr !== 12'h100) begin failures++; $display("FAIL upd_rght got=%h exp=100", sr); end
        checks++; if (sb !== 12'hC00) begin failures++; $display("FAIL upd_batt got=%h exp=C00", sb); end
        exp_reg[0] = 12'h200;
        exp_ptr = 1;
    endtask

    task automatic test_stray_done();
        int w0;
        w0 = wrt_cnt;
        rd_data = 16'hABCD;
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++; if (busy !== 1'b0 || rdy !== 1'b0) begin failures++; $display("FAIL stray_state got busy=%b rdy=%b exp 0 0", busy, rdy); end
            tick();
        end
        checks++; if (wrt_cnt != w0) begin failures++; $display("FAIL stray_wrt got=%0d exp=0", wrt_cnt - w0); end
        checks++; if (lft_ld !== exp_reg[0] || rght_ld !== exp_reg[1] || batt !== exp_reg[2]) begin
            failures++; $display("FAIL stray_regs got=%h/%h/%h exp=%h/%h/%h", lft_ld, rght_ld, batt, exp_reg[0], exp_reg[1], exp_reg[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] c1, c2;
        int lat, gap;
        logic rs, ba, ra;
        logic [1:0] id;
        logic [11:0] sl, sr, sb;
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        checks++; if (wrt !== 1'b1 || cmd !== 16'h2000) begin failures++; $display("FAIL mid_first_wrt got wrt=%b cmd=%h exp 1 2000", wrt, cmd); end
        repeat (2) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_gap got=%b exp=1", busy); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (wrt !== 1'b0 || cmd !== 16'h0000 || busy !== 1'b0 || rdy !== 1'b0 || rdy_id !== 2'd0) begin
            failures++; $display("FAIL mid_async_ctl got wrt=%b cmd=%h busy=%b rdy=%b id=%0d exp all 0", wrt, cmd, busy, rdy, rdy_id);
        end
        checks++; if (lft_ld !== 12'h000 || rght_ld !== 12'h000 || batt !== 12'h000) begin
            failures++; $display("FAIL mid_async_regs got=%h/%h/%h exp=000/000/000", lft_ld, rght_ld, batt);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_ptr = 0;
        for (int i = 0; i < 3; i++) exp_reg[i] = 12'h000;
        tick();
        convert(4'h7, c1, c2, lat, gap, rs, id, sl, sr, sb, ba, ra);
        exp_reg[0] = adc[0];
        checks++; if (c1 !== 16'h0000) begin failures++; $display("FAIL mid_restart_cmd got=%h exp=0000", c1); end
        checks++; if (id !== 2'd0 || rs !== 1'b1) begin failures++; $display("FAIL mid_restart_rdy got rdy=%b id=%0d exp 1 0", rs, id); end
        checks++; if (sl !== exp_reg[0] || sr !== 12'h000 || sb !== 12'h000) begin
            failures++; $display("FAIL mid_restart_regs got=%h/%h/%h exp=%h/000/000", sl, sr, sb, exp_reg[0]);
        end
        exp_ptr = 1;
    endtask

    task automatic test_batt_upper();
        logic [15:0] c1, c2;
        int lat, gap;
        logic rs, ba, ra;
        logic [1:0] id;
        logic [11:0] sl, sr, sb;
        adc[4] = 12'h5A5;
        convert(4'h3, c1, c2, lat, gap, rs, id, sl, sr, sb, ba, ra);
        checks++; if (sr !== 12'h5A5) begin failures++; $display("FAIL bu_rght got=%h exp=5A5", sr); end
        exp_reg[1] = 12'h5A5;
        adc[5] = 12'h123;
        convert(4'hF, c1, c2, lat, gap, rs, id, sl, sr, sb, ba, ra);
        checks++; if (c1 !== 16'h2800) begin failures++; $display("FAIL bu_cmd got=%h exp=2800", c1); end
        checks++; if (id !== 2'd2) begin failures++; $display("FAIL bu_rdy_id got=%0d exp=2", id); end
        checks++; if (sb !== 12'h123) begin failures++; $display("FAIL bu_batt got=%h exp=123", sb); end
        checks++; if (sl !== exp_reg[0] || sr !== exp_reg[1]) begin failures++; $display("FAIL bu_others got=%h/%h exp=%h/%h", sl, sr, exp_reg[0], exp_reg[1]); end
        exp_reg[2] = 12'h123;
        exp_ptr = 0;
    endtask

    task automatic test_back_to_back();
        int phase = 0;
        int pend = 0;
        int done_cyc = 0;
        int rdy_cyc = 0;
        int convs = 0;
        int w0;
        bit first = 1'b1;
        bit stop = 1'b0;
        logic [15:0] cur_cmd = 16'h0;
        logic [15:0] r;
        logic [11:0] pend_val = 12'h0;
        w0 = wrt_cnt;
        nxt = 1'b1;
        for (int cyc = 0; cyc < 2400 && !stop; cyc++) begin
            tick();
            done = 1'b0;
            if (wrt === 1'b1) begin
                if (phase == 0) begin
                    checks++; if (cmd !== exp_cmd(exp_ptr)) begin failures++; $display("FAIL b2b_cmd got=%h exp=%h", cmd, exp_cmd(exp_ptr)); end
                    if (!first) begin
                        checks++; if (cyc != rdy_cyc + 2) begin failures++; $display("FAIL b2b_restart got=%0d exp=%0d", cyc - rdy_cyc, 2); end
                    end
                    first = 1'b0;
                    cur_cmd = cmd;
                    phase = 1;
                    pend = $urandom_range(1, 6);
                end else if (phase == 2) begin
                    checks++; if (cyc - done_cyc != GAP_CYC) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", cyc - done_cyc, GAP_CYC); end
                    checks++; if (cmd !== cur_cmd) begin failures++; $display("FAIL b2b_cmd_stable got=%h exp=%h", cmd, cur_cmd); end
                    phase = 3;
                    pend = $urandom_range(1, 6);
                end else begin
                    checks++; failures++;
                    $display("FAIL b2b_extra_wrt got=wrt in phase %0d exp=no wrt", phase);
                end
            end
            if (rdy === 1'b1) begin
                checks++; if (phase != 4) begin failures++; $display("FAIL b2b_rdy_phase got=%0d exp=4", phase); end
                checks++; if (rdy_id !== 2'(exp_ptr)) begin failures++; $display("FAIL b2b_rdy_id got=%0d exp=%0d", rdy_id, exp_ptr); end
                exp_reg[exp_ptr] = pend_val;
                checks++; if (lft_ld !== exp_reg[0] || rght_ld !== exp_reg[1] || batt !== exp_reg[2]) begin
                    failures++; $display("FAIL b2b_regs got=%h/%h/%h exp=%h/%h/%h", lft_ld, rght_ld, batt, exp_reg[0], exp_reg[1], exp_reg[2]);
                end
                exp_ptr = (exp_ptr + 1) % 3;
                convs++;
                rdy_cyc = cyc;
                phase = 0;
                if (cyc >= 2000) begin
                    nxt = 1'b0;
                    stop = 1'b1;
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    r = 16'($urandom);
                    rd_data = r;
                    done = 1'b1;
                    if (phase == 1) begin
                        done_cyc = cyc + 1;
                        phase = 2;
                    end else begin
                        pend_val = r[11:0];
                        phase = 4;
                    end
                end
            end
        end
        nxt = 1'b0;
        done = 1'b0;
        repeat (3) tick();
        checks++; if (stop !== 1'b1) begin failures++; $display("FAIL b2b_timeout got=no final rdy exp=final rdy"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
        checks++; if (wrt_cnt - w0 != 2 * convs) begin failures++; $display("FAIL b2b_wrt_total got=%0d exp=%0d", wrt_cnt - w0, 2 * convs); end
        checks++; if (convs < 50) begin failures++; $display("FAIL b2b_conv_count got=%0d exp>=50", convs); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_update_one();
        test_stray_done();
        test_reset_mid();
        test_batt_upper();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
